// File: rtl/bcd_counter_chain_if.sv
// Bus bundle for bcd_counter_chain: control inputs, load data, count and carry outputs.
// Optional feature macro: BCD_UPDOWN_EN adds the up_dn direction signal.
interface bcd_counter_chain_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic [DIGITS-1:0]     digit_tc;
    logic                  tc;
    logic                  wrap;
`ifdef BCD_UPDOWN_EN
    logic                  up_dn;
`endif

    // Driver side: the clock divider / control logic upstream
    modport master (
        output en, clr, load, load_val,
`ifdef BCD_UPDOWN_EN
        output up_dn,
`endif
        input  count, digit_tc, tc, wrap
    );

    // Counter side
    modport slave (
        input  en, clr, load, load_val,
`ifdef BCD_UPDOWN_EN
        input  up_dn,
`endif
        output count, digit_tc, tc, wrap
    );
endinterface

// File: rtl/bcd_counter_chain.sv
// Synchronous N-digit cascaded BCD counter; digits share clk_div and are
// enabled through a combinational carry chain (no ripple clocking).
// Optional feature macro: BCD_UPDOWN_EN enables down-counting via up_dn.
module bcd_counter_chain #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic               clk_div,
    input  logic               rst,
    bcd_counter_chain_if.slave bus
);
    localparam int unsigned CW = 4 * DIGITS;

    logic [DIGITS:0] carry;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_step;
    logic [CW-1:0]   load_clean;
    logic            wrap_q;
    logic            sat_hold;
    logic [3:0]      dig;
    logic [3:0]      lv_dig;

    // Carry chain, per-digit step values and sanitised load data
    always_comb begin
        carry      = '0;
        count_step = count_q;
        load_clean = '0;
        dig        = '0;
        lv_dig     = '0;
        carry[0]   = bus.en & ~bus.clr & ~bus.load;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = count_q[4*i +: 4];
`ifdef BCD_UPDOWN_EN
            if (!bus.up_dn) begin
                carry[i+1] = carry[i] & (dig == 4'd0);
                if (carry[i]) begin
                    count_step[4*i +: 4] = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
                end
            end else
`endif
            begin
                carry[i+1] = carry[i] & (dig == 4'd9);
                if (carry[i]) begin
                    count_step[4*i +: 4] = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
                end
            end
            // Non-BCD nibbles load as zero so count can never leave 0..9
            lv_dig = bus.load_val[4*i +: 4];
            load_clean[4*i +: 4] = (lv_dig > 4'd9) ? 4'd0 : lv_dig;
        end
    end

    // Saturating build freezes the count at the terminal value
    assign sat_hold = carry[DIGITS] & ~WRAP;

    // Count and wrap-pulse registers; priority rst > clr > load > en
    always_ff @(posedge clk_div) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clean;
            wrap_q  <= 1'b0;
        end else if (carry[0]) begin
            if (!sat_hold) begin
                count_q <= count_step;
            end
            wrap_q <= carry[DIGITS] & WRAP;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.digit_tc = carry[DIGITS:1];
    assign bus.tc       = carry[DIGITS];
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Bench for bcd_counter_chain: one wrapping and one saturating instance driven
// in lockstep, checked against an integer-valued decimal model every cycle.
module tb_bcd_counter_chain;
    localparam int unsigned D    = 4;
    localparam int          MAXV = 9999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             t_rst  = 1'b0;
    logic             t_clr  = 1'b0;
    logic             t_load = 1'b0;
    logic             t_en   = 1'b0;
    logic             t_dir  = 1'b1;
    logic [4*D-1:0]   t_lv   = '0;

    bcd_counter_chain_if #(.DIGITS(D)) b1 ();
    bcd_counter_chain_if #(.DIGITS(D)) b0 ();

    assign b1.en = t_en;   assign b1.clr = t_clr; assign b1.load = t_load; assign b1.load_val = t_lv;
    assign b0.en = t_en;   assign b0.clr = t_clr; assign b0.load = t_load; assign b0.load_val = t_lv;
`ifdef BCD_UPDOWN_EN
    assign b1.up_dn = t_dir;
    assign b0.up_dn = t_dir;
`endif

    bcd_counter_chain #(.DIGITS(D), .WRAP(1'b1)) dut_w (.clk_div(clk), .rst(t_rst), .bus(b1.slave));
    bcd_counter_chain #(.DIGITS(D), .WRAP(1'b0)) dut_s (.clk_div(clk), .rst(t_rst), .bus(b0.slave));

    int errors = 0;
    int checks = 0;
    int mv[2];
    bit mw[2];
    bit model_valid = 1'b0;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [4*D-1:0] lv);
        int v;
        int n;
        v = 0;
        for (int i = int'(D) - 1; i >= 0; i--) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 0;
            v = v * 10 + n;
        end
        return v;
    endfunction

    function automatic bit dir_up();
`ifdef BCD_UPDOWN_EN
        return t_dir;
`else
        return 1'b1;
`endif
    endfunction

    // Carry of digit i: the low i+1 decimal digits are all at the terminal value
    function automatic logic [D-1:0] exp_dtc(input int v, input bit ee, input bit up);
        logic [D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < int'(D); i++) begin
            p = p * 10;
            r[i] = ee && (up ? ((v % p) == p - 1) : ((v % p) == 0));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit ee;
        logic [D-1:0] d1;
        logic [D-1:0] d0;
        ee = t_en & ~t_clr & ~t_load;
        d1 = exp_dtc(mv[1], ee, dir_up());
        d0 = exp_dtc(mv[0], ee, dir_up());
        chk("w_count",    32'(b1.count),    32'(to_bcd(mv[1])));
        chk("w_wrap",     32'(b1.wrap),     32'(mw[1]));
        chk("w_digit_tc", 32'(b1.digit_tc), 32'(d1));
        chk("w_tc",       32'(b1.tc),       32'(d1[D-1]));
        chk("s_count",    32'(b0.count),    32'(to_bcd(mv[0])));
        chk("s_wrap",     32'(b0.wrap),     32'(mw[0]));
        chk("s_digit_tc", 32'(b0.digit_tc), 32'(d0));
        chk("s_tc",       32'(b0.tc),       32'(d0[D-1]));
    endtask

    // One clock: compare, advance model from sampled inputs, land on next negedge
    task automatic step();
        int nv[2];
        bit nw[2];
        #1;
        if (model_valid) compare_all();
        for (int w = 0; w < 2; w++) begin
            nv[w] = mv[w];
            nw[w] = 1'b0;
            if (t_rst || t_clr) begin
                nv[w] = 0;
            end else if (t_load) begin
                nv[w] = load_value(t_lv);
            end else if (t_en) begin
                if (dir_up()) begin
                    if (mv[w] == MAXV) begin
                        if (w == 1) begin nv[w] = 0; nw[w] = 1'b1; end
                    end else nv[w] = mv[w] + 1;
                end else begin
                    if (mv[w] == 0) begin
                        if (w == 1) begin nv[w] = MAXV; nw[w] = 1'b1; end
                    end else nv[w] = mv[w] - 1;
                end
            end
        end
        @(posedge clk);
        mv[0] = nv[0]; mv[1] = nv[1];
        mw[0] = nw[0]; mw[1] = nw[1];
        if (t_rst) model_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input bit e, input logic [4*D-1:0] lv);
        t_rst = r; t_clr = c; t_load = l; t_en = e; t_lv = lv;
    endtask

    initial begin
        mv[0] = 0; mv[1] = 0; mw[0] = 1'b0; mw[1] = 1'b0;
        @(negedge clk);

        // Reset two cycles with en high, then count twelve
        drive(1, 0, 0, 1, '0);
        step(); step();
        chk("t1_reset_count", 32'(b1.count), 32'h0000);
        chk("t1_reset_wrap",  32'(b1.wrap),  32'h0);
        drive(0, 0, 0, 1, '0);
        for (int k = 0; k < 12; k++) step();
        chk("t1_count12",       32'(b1.count),      32'h0012);
        chk("t1_model12",       32'(to_bcd(mv[1])), 32'h0012);

        // Carry across three nines
        drive(0, 0, 1, 1, 16'h0999);
        step();
        drive(0, 0, 0, 1, '0);
        #1;
        chk("t2_digit_tc", 32'(b1.digit_tc), 32'b0111);
        chk("t2_tc",       32'(b1.tc),       32'h0);
        step();
        chk("t2_count1000", 32'(b1.count), 32'h1000);

        // Rollover vs saturation from 9999
        drive(0, 0, 1, 0, 16'h9999);
        step();
        drive(0, 0, 0, 1, '0);
        #1;
        chk("t3_tc", 32'(b1.tc), 32'h1);
        step();
        chk("t3_count0",  32'(b1.count), 32'h0000);
        chk("t3_wrap1",   32'(b1.wrap),  32'h1);
        chk("t4_sat_hold", 32'(b0.count), 32'h9999);
        drive(0, 0, 0, 0, '0);
        step();
        chk("t3_wrap_once", 32'(b1.wrap), 32'h0);

        // Saturating instance held at 9999 with en high
        drive(0, 0, 0, 1, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_tc", 32'(b0.tc), 32'h1);
            step();
            chk("t4_count", 32'(b0.count), 32'h9999);
            chk("t4_wrap",  32'(b0.wrap),  32'h0);
        end

        // Priority and invalid-nibble load
        drive(0, 0, 1, 1, 16'h1234);
        step();
        chk("t5_load", 32'(b1.count), 32'h1234);
        drive(0, 1, 1, 1, 16'h5678);
        step();
        chk("t5_clr_wins", 32'(b1.count), 32'h0000);
        drive(0, 0, 1, 0, 16'h12A4);
        step();
        chk("t5_invalid", 32'(b1.count), 32'h1204);
        chk("t5_model",   32'(to_bcd(mv[1])), 32'h1204);

`ifdef BCD_UPDOWN_EN
        // Down-count rollover from 0000
        t_dir = 1'b0;
        drive(0, 0, 1, 0, 16'h0000);
        step();
        drive(0, 0, 0, 1, '0);
        #1;
        chk("t6_tc", 32'(b1.tc), 32'h1);
        step();
        chk("t6_count9999", 32'(b1.count), 32'h9999);
        chk("t6_wrap",      32'(b1.wrap),  32'h1);
        step();
        chk("t6_count9998", 32'(b1.count), 32'h9998);
        t_dir = 1'b1;
`endif

        // Randomised traffic, biased toward terminal values
        for (int k = 0; k < 600; k++) begin
            logic [4*D-1:0] lv;
            int sel;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      lv = to_bcd(int'($urandom_range(9990, 9999)));
            else if (sel == 1) lv = to_bcd(int'($urandom_range(0, 10)));
            else if (sel == 2) lv = to_bcd(int'($urandom_range(0, 9999)));
            else               lv = (4*D)'($urandom);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 99) < 85), lv);
`ifdef BCD_UPDOWN_EN
            t_dir = 1'($urandom_range(0, 1));
`endif
            step();
        end

        // Idle with en low: everything stable and quiet
        drive(0, 0, 0, 0, '0);
        for (int k = 0; k < 4; k++) step();
        #1;
        chk("idle_tc", 32'(b1.tc), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
